// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline with a memory-stall
//            watchdog. Optional perf counters are enabled by STALL_PERF_EN.
// Revision : 1.0
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int CNT_W     = 8,
    parameter int MAX_STALL = 200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        mem_stall_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rd_i,
    input  logic [4:0]  ifid_rs1_i,
    input  logic [4:0]  ifid_rs2_i,
    input  logic        ifid_use_rs2_i,
    input  logic        branch_taken_i,
    output logic        pc_we_o,
    output logic        ifid_we_o,
    output logic        ifid_flush_o,
    output logic        idex_we_o,
    output logic        idex_bubble_o,
    output logic        exmem_we_o,
    output logic        memwb_we_o,
`ifdef STALL_PERF_EN
    output logic [31:0] perf_bubble_o,
    output logic [31:0] perf_memstall_o,
    output logic [31:0] perf_flush_o,
`endif
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_STALL);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_timeout;
    logic             w_active;
    logic             w_load_use;
    logic             w_memstall;
    logic             w_bubble;
    logic             w_flush;

    assign w_load_use = idex_memread_i && (idex_rd_i != 5'd0) &&
                        ((idex_rd_i == ifid_rs1_i) ||
                         (ifid_use_rs2_i && (idex_rd_i == ifid_rs2_i)));

    // Priority: idle/frozen, then memory stall, then load-use, then branch.
    assign w_active   = (r_state != S_IDLE) && start_i;
    assign w_memstall = w_active && mem_stall_i;
    assign w_bubble   = w_active && !mem_stall_i && w_load_use;
    assign w_flush    = w_active && !mem_stall_i && !w_load_use && branch_taken_i;

    always_comb begin
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_we_o     = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_we_o    = 1'b0;
        memwb_we_o    = 1'b0;
        if (w_active && !mem_stall_i) begin
            idex_we_o  = 1'b1;
            exmem_we_o = 1'b1;
            memwb_we_o = 1'b1;
            if (w_load_use) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_we_o      = 1'b1;
                ifid_we_o    = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!start_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     w_state_nxt = S_RUN;
                S_RUN:      if (mem_stall_i) w_state_nxt = S_MEM_WAIT;
                S_MEM_WAIT: if (!mem_stall_i) w_state_nxt = S_RUN;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    // The count only advances while the FSM remains in MEM_WAIT; every exit clears it.
    always_comb begin
        w_cnt_nxt = '0;
        if ((r_state == S_MEM_WAIT) && (w_state_nxt == S_MEM_WAIT)) begin
            w_cnt_nxt = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == C_MAX) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;

`ifdef STALL_PERF_EN
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_memstall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_perf_bubble   <= '0;
            r_perf_memstall <= '0;
            r_perf_flush    <= '0;
        end else begin
            if (w_bubble)   r_perf_bubble   <= r_perf_bubble + 32'd1;
            if (w_memstall) r_perf_memstall <= r_perf_memstall + 32'd1;
            if (w_flush)    r_perf_flush    <= r_perf_flush + 32'd1;
        end
    end

    assign perf_bubble_o   = r_perf_bubble;
    assign perf_memstall_o = r_perf_memstall;
    assign perf_flush_o    = r_perf_flush;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_bubble ^ w_memstall ^ w_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_ctrl
// Brief    : Scoreboard bench for pipeline_stall_ctrl: directed scenarios plus
//            randomized traffic against a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_pipeline_stall_ctrl;

    localparam int MAXS = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0, mem_stall_i = 1'b0, idex_memread_i = 1'b0;
    logic [4:0] idex_rd_i = '0, ifid_rs1_i = '0, ifid_rs2_i = '0;
    logic       ifid_use_rs2_i = 1'b0, branch_taken_i = 1'b0;
    logic       pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o;
    logic       exmem_we_o, memwb_we_o, timeout_o;
`ifdef STALL_PERF_EN
    logic [31:0] perf_bubble_o, perf_memstall_o, perf_flush_o;
    int unsigned n_bub = 0, n_ms = 0, n_fl = 0;
`endif

    always #5 clk_i = ~clk_i;

    pipeline_stall_ctrl #(.CNT_W(8), .MAX_STALL(MAXS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mem_stall_i(mem_stall_i),
        .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
        .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
        .ifid_use_rs2_i(ifid_use_rs2_i), .branch_taken_i(branch_taken_i),
        .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
        .idex_we_o(idex_we_o), .idex_bubble_o(idex_bubble_o),
        .exmem_we_o(exmem_we_o), .memwb_we_o(memwb_we_o),
`ifdef STALL_PERF_EN
        .perf_bubble_o(perf_bubble_o), .perf_memstall_o(perf_memstall_o),
        .perf_flush_o(perf_flush_o),
`endif
        .timeout_o(timeout_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [7:0] exp_q[$];

    // Reference model: "where the pipeline is" plus watchdog bookkeeping.
    bit m_running = 0, m_waiting = 0, m_to = 0;
    int m_cnt = 0;

    function automatic logic [7:0] dut_vec();
        return {pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o,
                exmem_we_o, memwb_we_o, timeout_o};
    endfunction

    task automatic model_reset();
        m_running = 0; m_waiting = 0; m_cnt = 0; m_to = 0;
    endtask

    task automatic step(input bit st, input bit ms, input bit mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input bit u2, input bit br);
        bit         lu;
        logic [6:0] ctl;
        @(negedge clk_i);
        start_i = st; mem_stall_i = ms; idex_memread_i = mr; idex_rd_i = rd;
        ifid_rs1_i = r1; ifid_rs2_i = r2; ifid_use_rs2_i = u2; branch_taken_i = br;
        lu = mr && rd != 0 && (rd == r1 || (u2 && rd == r2));
        // order: pc, ifid, flush, idex, bubble, exmem, memwb
        if (!(m_running || m_waiting) || !st) ctl = 7'b0000000;
        else if (ms)                          ctl = 7'b0000000;
        else if (lu)                          ctl = 7'b0001111;
        else if (br)                          ctl = 7'b1111011;
        else                                  ctl = 7'b1101011;
`ifdef STALL_PERF_EN
        if ((m_running || m_waiting) && st) begin
            if (ms) n_ms++;
            else if (lu) n_bub++;
            else if (br) n_fl++;
        end
`endif
        exp_q.push_back({ctl, m_to});
        if (!st) begin
            model_reset_keep_to();
        end else if (!m_running && !m_waiting) begin
            m_running = 1;
        end else if (m_running) begin
            if (ms) begin m_running = 0; m_waiting = 1; end
        end else if (ms) begin
            if (m_cnt < MAXS) m_cnt++;
            if (m_cnt == MAXS) m_to = 1;
        end else begin
            m_waiting = 0; m_running = 1; m_cnt = 0;
        end
    endtask

    task automatic model_reset_keep_to();
        m_running = 0; m_waiting = 0; m_cnt = 0;
    endtask

    task automatic run(input bit st, input bit ms);
        step(st, ms, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic mid_reset();
        #3;
        rst_i = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", dut_vec(), 8'h00);
        end
        model_reset();
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Monitor: compares every cycle for which the driver pushed an expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                cyc++;
                if (dut_vec() !== e) begin
                    errors++;
                    $display("FAIL cyc%0d outputs(pc,ifid,fl,idex,bub,exm,mwb,to) got=%b exp=%b",
                             cyc, dut_vec(), e);
                end
            end
        end
    end

    initial begin
        int ms_left = 0;
        bit ms;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (dut_vec() !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", dut_vec(), 8'h00);
        end
        @(negedge clk_i);
        rst_i = 1'b1;

        // T1: held off, then start; first started cycle is still idle
        run(0, 0); run(0, 0); run(1, 0); run(1, 0);
        // T2: load-use bubble, then clear; rd=0 never bubbles
        step(1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        step(1, 0, 0, 5'd5, 5'd5, 5'd0, 0, 0);
        step(1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0);
        step(1, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0);
        // T3: stall dominates load-use and branch, then bubble, then flush
        repeat (3) step(1, 1, 1, 5'd3, 5'd3, 5'd0, 0, 1);
        step(1, 0, 1, 5'd3, 5'd3, 5'd0, 0, 1);
        step(1, 0, 0, 5'd3, 5'd3, 5'd0, 0, 1);
        run(1, 0);
        // T4: bubble and branch together
        step(1, 0, 1, 5'd9, 5'd2, 5'd9, 1, 1);
        step(1, 0, 0, 5'd9, 5'd2, 5'd9, 1, 1);
        run(1, 0);
        // short stall runs never reach the watchdog (count clears on exit)
        repeat (3) run(1, 1);
        run(1, 0);
        repeat (3) run(1, 1);
        run(1, 0);
        // T5: long stall sets the sticky timeout
        repeat (6) run(1, 1);
        repeat (3) run(1, 0);
        run(0, 0); run(1, 0); run(1, 0);
        // T6: reset mid MEM_WAIT with count 3, then a fresh 4-edge-short stall
        repeat (4) run(1, 1);
        mid_reset();
        run(1, 0); run(1, 0);
        repeat (4) run(1, 1);
        run(1, 0);

        for (int i = 0; i < 1500; i++) begin
            if (ms_left > 0) begin
                ms = 1; ms_left--;
            end else begin
                ms = 0;
                if ($urandom_range(0, 9) == 0) ms_left = $urandom_range(1, 7);
            end
            step($urandom_range(0, 24) != 0, ms, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                 5'($urandom_range(0, 5)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0);
            if (i == 700) mid_reset();
        end

        repeat (3) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
`ifdef STALL_PERF_EN
        #3;
        checks++;
        if (perf_bubble_o !== n_bub || perf_memstall_o !== n_ms || perf_flush_o !== n_fl) begin
            errors++;
            $display("FAIL perf_counters got=%0d/%0d/%0d exp=%0d/%0d/%0d", perf_bubble_o,
                     perf_memstall_o, perf_flush_o, n_bub, n_ms, n_fl);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

`ifdef STALL_PERF_EN
    // Perf counters are cleared by the mid-run resets, so the model follows them.
    always @(negedge rst_i) begin
        n_bub = 0; n_ms = 0; n_fl = 0;
    end
`endif

endmodule
`default_nettype wire
